// File: rtl/release_sequencer_if.sv
// Bundle between release_sequencer and its lanes/upstream/downstream.
// slave is the sequencer side; master is the lane/driver side.
interface release_sequencer_if #(
   parameter int NUM_LANES = 4
);
   logic                 i_start;
   logic [NUM_LANES-1:0] i_lane_present;
   logic [NUM_LANES-1:0] i_lane_joined;
   logic [NUM_LANES-1:0] i_lane_last;
   logic                 i_out_ready;
   logic [31:0]          o_next;
   logic [NUM_LANES-1:0] o_release;
   logic [31:0]          o_window_limit;
   logic [31:0]          o_released_cnt;
   logic                 o_done;
   logic                 o_stall_err;
   logic                 o_dup_err;

   modport master (
      output i_start,
      output i_lane_present,
      output i_lane_joined,
      output i_lane_last,
      output i_out_ready,
      input  o_next,
      input  o_release,
      input  o_window_limit,
      input  o_released_cnt,
      input  o_done,
      input  o_stall_err,
      input  o_dup_err
   );

   modport slave (
      input  i_start,
      input  i_lane_present,
      input  i_lane_joined,
      input  i_lane_last,
      input  i_out_ready,
      output o_next,
      output o_release,
      output o_window_limit,
      output o_released_cnt,
      output o_done,
      output o_stall_err,
      output o_dup_err
   );
endinterface

// File: rtl/release_sequencer.sv
// Central in-order release controller for store-and-release lanes.
// Owns the serial counter and issues one-hot single-cycle release pulses.
module release_sequencer #(
   parameter int NUM_LANES   = 4,
   parameter int MAX_NUM     = 2,
   parameter int STALL_LIMIT = 1024
) (
   input logic               clk,
   input logic               resetn,
   release_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_BUBBLE,
      S_DONE
   } state_t;

   localparam logic [NUM_LANES-1:0] LANE_ONE =
      {{(NUM_LANES-1){1'b0}}, 1'b1};
   localparam logic [31:0] STALL_MAX = 32'(STALL_LIMIT);
   localparam logic [31:0] WIN       = 32'(MAX_NUM);

   state_t      r_state;
   logic [31:0] r_next;
   logic [31:0] r_cnt;
   logic [31:0] r_stall_cnt;
   logic        r_stall_err;
   logic        r_dup_err;

   state_t               w_state_nxt;
   logic [31:0]          w_next_nxt;
   logic [31:0]          w_cnt_nxt;
   logic [31:0]          w_stall_cnt_nxt;
   logic                 w_stall_err_nxt;
   logic                 w_dup_err_nxt;
   logic [NUM_LANES-1:0] w_release;

   logic [NUM_LANES-1:0] w_present;
   logic [NUM_LANES-1:0] w_sel;
   logic                 w_hit;
   logic                 w_multi;
   logic                 w_sel_joined;
   logic                 w_all_last;

   assign w_present    = bus.i_lane_present;
   assign w_hit        = |w_present;
   // isolate the lowest set bit: x & -x
   assign w_sel        = w_present & (~w_present + LANE_ONE);
   assign w_multi      = |(w_present & (w_present - LANE_ONE));
   assign w_sel_joined = |(w_sel & bus.i_lane_joined);
   assign w_all_last   = &bus.i_lane_last;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_next      <= '0;
         r_cnt       <= '0;
         r_stall_cnt <= '0;
         r_stall_err <= 1'b0;
         r_dup_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_next      <= w_next_nxt;
         r_cnt       <= w_cnt_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
         r_stall_err <= w_stall_err_nxt;
         r_dup_err   <= w_dup_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_next_nxt      = r_next;
      w_cnt_nxt       = r_cnt;
      w_stall_cnt_nxt = r_stall_cnt;
      w_stall_err_nxt = r_stall_err;
      w_dup_err_nxt   = r_dup_err;
      w_release       = '0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.i_start) begin
               w_state_nxt     = S_RUN;
               w_next_nxt      = '0;
               w_cnt_nxt       = '0;
               w_stall_cnt_nxt = '0;
               w_stall_err_nxt = 1'b0;
               w_dup_err_nxt   = 1'b0;
            end
         end
         S_RUN: begin
            if (w_multi) begin
               w_dup_err_nxt = 1'b1;
            end
            if (w_hit) begin
               // a dropped (non-joined) tuple needs no downstream slot
               if (!w_sel_joined || bus.i_out_ready) begin
                  w_release       = w_sel;
                  w_next_nxt      = r_next + 32'd1;
                  w_stall_cnt_nxt = '0;
                  w_state_nxt     = S_BUBBLE;
                  if (w_sel_joined) begin
                     w_cnt_nxt = r_cnt + 32'd1;
                  end
               end
            end else if (w_all_last) begin
               w_state_nxt = S_DONE;
            end else begin
               if (r_stall_cnt < STALL_MAX) begin
                  w_stall_cnt_nxt = r_stall_cnt + 32'd1;
               end
               if (r_stall_cnt + 32'd1 >= STALL_MAX) begin
                  w_stall_err_nxt = 1'b1;
               end
            end
         end
         S_BUBBLE: begin
            w_state_nxt = S_RUN;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (!resetn) begin
         w_release = '0;
      end
   end

   assign bus.o_next         = r_next;
   assign bus.o_release      = w_release;
   assign bus.o_window_limit = r_next + WIN;
   assign bus.o_released_cnt = r_cnt;
   assign bus.o_done         = (r_state == S_DONE);
   assign bus.o_stall_err    = r_stall_err;
   assign bus.o_dup_err      = r_dup_err;

endmodule

// File: tb/tb_release_sequencer.sv
// Directed bench for release_sequencer with immediate-assert checks.
module tb_release_sequencer;

   logic clk;
   logic resetn;
   int   total;
   int   bad;

   release_sequencer_if #(.NUM_LANES(4)) bus ();

   release_sequencer #(
      .NUM_LANES  (4),
      .MAX_NUM    (2),
      .STALL_LIMIT(8)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag, input logic [3:0] exp_rel);
      #1;
      chk(tag, {28'd0, bus.o_release}, {28'd0, exp_rel});
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] p,
                        input logic [3:0] j,
                        input logic [3:0] l,
                        input logic r);
      bus.i_lane_present = p;
      bus.i_lane_joined  = j;
      bus.i_lane_last    = l;
      bus.i_out_ready    = r;
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      bus.i_start = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic do_start();
      bus.i_start = 1'b1;
      tick("start_rel", 4'h0);
      bus.i_start = 1'b0;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      bus.i_start = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 1'b1);
      @(negedge clk);

      // reset state
      resetn = 1'b0;
      drive(4'hF, 4'hF, 4'h0, 1'b1);
      @(negedge clk);
      #1;
      chk("rst_next", bus.o_next, 32'd0);
      chk("rst_release", {28'd0, bus.o_release}, 32'd0);
      chk("rst_win", bus.o_window_limit, 32'd2);
      chk("rst_cnt", bus.o_released_cnt, 32'd0);
      chk("rst_done", {31'd0, bus.o_done}, 32'd0);
      chk("rst_stall", {31'd0, bus.o_stall_err}, 32'd0);
      chk("rst_dup", {31'd0, bus.o_dup_err}, 32'd0);
      @(negedge clk);

      // steady lane0 stream
      do_reset();
      do_start();
      drive(4'h1, 4'h1, 4'h0, 1'b1);
      tick("t1_c1", 4'h1);
      tick("t1_c2", 4'h0);
      tick("t1_c3", 4'h1);
      tick("t1_c4", 4'h0);
      tick("t1_c5", 4'h1);
      tick("t1_c6", 4'h0);
      tick("t1_c7", 4'h1);
      drive(4'h0, 4'h0, 4'h0, 1'b1);
      tick("t1_c8", 4'h0);
      chk("t1_next", bus.o_next, 32'd4);
      chk("t1_cnt", bus.o_released_cnt, 32'd4);
      chk("t1_win", bus.o_window_limit, 32'd6);

      // backpressure on joined, non-joined ignores it
      do_reset();
      do_start();
      drive(4'h4, 4'h4, 4'h0, 1'b0);
      tick("t2_hold1", 4'h0);
      tick("t2_hold2", 4'h0);
      tick("t2_hold3", 4'h0);
      chk("t2_next_held", bus.o_next, 32'd0);
      bus.i_out_ready = 1'b1;
      tick("t2_rel0", 4'h4);
      drive(4'h2, 4'h0, 4'h0, 1'b0);
      tick("t2_bubble", 4'h0);
      tick("t2_rel1", 4'h2);
      drive(4'h0, 4'h0, 4'h0, 1'b0);
      tick("t2_bubble2", 4'h0);
      chk("t2_cnt", bus.o_released_cnt, 32'd1);
      chk("t2_next", bus.o_next, 32'd2);

      // duplicate presence
      do_reset();
      do_start();
      chk("t3_dup_pre", {31'd0, bus.o_dup_err}, 32'd0);
      drive(4'h9, 4'h9, 4'h0, 1'b1);
      tick("t3_rel", 4'h1);
      drive(4'h0, 4'h0, 4'h0, 1'b1);
      tick("t3_bubble", 4'h0);
      chk("t3_dup", {31'd0, bus.o_dup_err}, 32'd1);
      chk("t3_next", bus.o_next, 32'd1);

      // stall detection
      do_reset();
      do_start();
      for (int i = 0; i < 7; i++) begin
         tick("t4_idle", 4'h0);
      end
      chk("t4_stall7", {31'd0, bus.o_stall_err}, 32'd0);
      tick("t4_idle8", 4'h0);
      chk("t4_stall8", {31'd0, bus.o_stall_err}, 32'd1);
      chk("t4_next0", bus.o_next, 32'd0);
      drive(4'h2, 4'h2, 4'h0, 1'b1);
      tick("t4_rel", 4'h2);
      drive(4'h0, 4'h0, 4'h0, 1'b1);
      tick("t4_bubble", 4'h0);
      chk("t4_stall_sticky", {31'd0, bus.o_stall_err}, 32'd1);
      chk("t4_next1", bus.o_next, 32'd1);

      // completion and restart
      do_reset();
      do_start();
      drive(4'h1, 4'h1, 4'h0, 1'b1);
      tick("t5_rel0", 4'h1);
      tick("t5_bub0", 4'h0);
      tick("t5_rel1", 4'h1);
      drive(4'h0, 4'h0, 4'hF, 1'b1);
      tick("t5_bub1", 4'h0);
      chk("t5_done_pre", {31'd0, bus.o_done}, 32'd0);
      tick("t5_nohit", 4'h0);
      chk("t5_done", {31'd0, bus.o_done}, 32'd1);
      chk("t5_next", bus.o_next, 32'd2);
      drive(4'h1, 4'h1, 4'hF, 1'b1);
      tick("t5_done_norel", 4'h0);
      drive(4'h0, 4'h0, 4'h0, 1'b1);
      do_start();
      chk("t5_done_clr", {31'd0, bus.o_done}, 32'd0);
      chk("t5_next_clr", bus.o_next, 32'd0);
      chk("t5_cnt_clr", bus.o_released_cnt, 32'd0);

      // reset aborts a pending release
      do_reset();
      do_start();
      drive(4'h1, 4'h1, 4'h0, 1'b1);
      resetn = 1'b0;
      tick("t6_rst_rel", 4'h0);
      resetn = 1'b1;
      tick("t6_after1", 4'h0);
      chk("t6_next", bus.o_next, 32'd0);
      tick("t6_after2", 4'h0);
      chk("t6_next2", bus.o_next, 32'd0);
      do_start();
      tick("t6_restart", 4'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
